// File: rtl/game_collision_detector_if.sv
// Pixel-enable inputs and frame-stable collision results of game_collision_detector.
// master = renderer/FSM side, slave = detector side.
interface game_collision_detector_if;
  logic       frame_start;
  logic       display_on;
  logic [2:0] target_rgb_en;
  logic       bullet_rgb_en;
  logic       spaceship_rgb_en;
  logic       clear;
  logic       collision;
  logic       collision_bullet;
  logic [2:0] bullet_hit_mask;
  logic       result_valid;

  modport master (
    output frame_start, display_on, target_rgb_en, bullet_rgb_en, spaceship_rgb_en, clear,
    input  collision, collision_bullet, bullet_hit_mask, result_valid
  );

  modport slave (
    input  frame_start, display_on, target_rgb_en, bullet_rgb_en, spaceship_rgb_en, clear,
    output collision, collision_bullet, bullet_hit_mask, result_valid
  );
endinterface

// File: rtl/game_collision_detector.sv
// Per-frame sprite overlap counter publishing collision levels at each frame boundary.
// GAME_COLLISION_THRESHOLD_EN selects CNT_W-bit counters vs MIN_PIXELS; otherwise 1-bit sticky flags.
//
//   state      | meaning
//   WAIT_FRAME | after reset/clear, pixels ignored until the first frame_start
//   ACCUM      | counting overlap pixels of the current frame
module game_collision_detector #(
  parameter int MIN_PIXELS = 4,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic rst,
  game_collision_detector_if.slave bus
);

`ifdef GAME_COLLISION_THRESHOLD_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  // Sticky mode is a saturating counter of width 1 with threshold 1.
  localparam int CW = THRESH_EN ? CNT_W : 1;
  localparam int TH = THRESH_EN ? MIN_PIXELS : 1;
  localparam logic [CW-1:0] TH_V    = CW'(TH);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {WAIT_FRAME, ACCUM} state_t;

  state_t        state;
  logic [CW-1:0] ship_cnt;
  logic [CW-1:0] bul_cnt [3];
  logic          ship_hit;
  logic [2:0]    bul_hit;
  logic          ship_over;
  logic [2:0]    bul_over;

  logic          collision_q;
  logic          collision_bullet_q;
  logic [2:0]    bullet_hit_mask_q;
  logic          result_valid_q;

  assign ship_hit = bus.display_on & bus.spaceship_rgb_en & (|bus.target_rgb_en);
  assign bul_hit  = {3{bus.display_on & bus.bullet_rgb_en}} & bus.target_rgb_en;

  always_comb begin
    ship_over = (ship_cnt >= TH_V);
    bul_over  = '0;
    for (int i = 0; i < 3; i++) bul_over[i] = (bul_cnt[i] >= TH_V);
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic hit);
    if (hit && (c != CNT_MAX)) return c + CW'(1);
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= WAIT_FRAME;
      ship_cnt           <= '0;
      for (int i = 0; i < 3; i++) bul_cnt[i] <= '0;
      collision_q        <= 1'b0;
      collision_bullet_q <= 1'b0;
      bullet_hit_mask_q  <= 3'b000;
      result_valid_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.clear) begin
        state              <= WAIT_FRAME;
        ship_cnt           <= '0;
        for (int i = 0; i < 3; i++) bul_cnt[i] <= '0;
        collision_q        <= 1'b0;
        collision_bullet_q <= 1'b0;
        bullet_hit_mask_q  <= 3'b000;
      end else if (state == WAIT_FRAME) begin
        if (bus.frame_start) begin
          state    <= ACCUM;
          ship_cnt <= CW'(ship_hit);
          for (int i = 0; i < 3; i++) bul_cnt[i] <= CW'(bul_hit[i]);
        end
      end else if (bus.frame_start) begin
        // The frame_start pixel is the first pixel of the new frame.
        collision_q        <= ship_over;
        bullet_hit_mask_q  <= bul_over;
        collision_bullet_q <= |bul_over;
        result_valid_q     <= 1'b1;
        ship_cnt           <= CW'(ship_hit);
        for (int i = 0; i < 3; i++) bul_cnt[i] <= CW'(bul_hit[i]);
      end else begin
        ship_cnt <= sat_inc(ship_cnt, ship_hit);
        for (int i = 0; i < 3; i++) bul_cnt[i] <= sat_inc(bul_cnt[i], bul_hit[i]);
      end
    end
  end

  assign bus.collision        = collision_q;
  assign bus.collision_bullet = collision_bullet_q;
  assign bus.bullet_hit_mask  = bullet_hit_mask_q;
  assign bus.result_valid     = result_valid_q;

endmodule

// File: tb/tb_game_collision_detector.sv
// Directed self-checking bench for game_collision_detector (MIN_PIXELS=4, CNT_W=8).
// Expectations follow GAME_COLLISION_THRESHOLD_EN the same way the build does.
module tb_game_collision_detector;

`ifdef GAME_COLLISION_THRESHOLD_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  game_collision_detector_if bus ();

  game_collision_detector #(.MIN_PIXELS(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic fs, input logic disp, input logic [2:0] tgt,
                     input logic bul, input logic ship, input logic clr);
    bus.frame_start      = fs;
    bus.display_on       = disp;
    bus.target_rgb_en    = tgt;
    bus.bullet_rgb_en    = bul;
    bus.spaceship_rgb_en = ship;
    bus.clear            = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ship_px(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fs_pulse();
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.frame_start = 1'b0; bus.display_on = 1'b0; bus.target_rgb_en = 3'b000;
    bus.bullet_rgb_en = 1'b0; bus.spaceship_rgb_en = 1'b0; bus.clear = 1'b0;
    #12;
    check("rst_collision", {31'd0, bus.collision}, 32'd0);
    check("rst_coll_bullet", {31'd0, bus.collision_bullet}, 32'd0);
    check("rst_mask", {29'd0, bus.bullet_hit_mask}, 32'd0);
    check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two empty frames: only the second frame_start publishes.
    fs_pulse();
    check("first_fs_valid", {31'd0, bus.result_valid}, 32'd0);
    idle(5);
    fs_pulse();
    check("second_fs_valid", {31'd0, bus.result_valid}, 32'd1);
    check("empty_collision", {31'd0, bus.collision}, 32'd0);
    check("empty_mask", {29'd0, bus.bullet_hit_mask}, 32'd0);
    idle(1);
    check("valid_one_cycle", {31'd0, bus.result_valid}, 32'd0);

    // 5 ship/target-2 overlaps.
    ship_px(5); idle(2); fs_pulse();
    check("ship5_collision", {31'd0, bus.collision}, 32'd1);
    check("ship5_coll_bullet", {31'd0, bus.collision_bullet}, 32'd0);
    check("ship5_valid", {31'd0, bus.result_valid}, 32'd1);
    idle(3); fs_pulse();
    check("empty_after_ship", {31'd0, bus.collision}, 32'd0);

    // 3 bullet/target-3 overlaps: below threshold, but set in sticky mode.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
    fs_pulse();
    check("bul3_mask", {29'd0, bus.bullet_hit_mask}, THR ? 32'd0 : 32'd4);
    check("bul3_coll_bullet", {31'd0, bus.collision_bullet}, THR ? 32'd0 : 32'd1);

    // Saturation: 300 and exactly 256 bullet/target-1 pixels.
    for (int k = 0; k < 300; k++) cyc(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    fs_pulse();
    check("bul300_mask", {29'd0, bus.bullet_hit_mask}, 32'd1);
    check("bul300_coll_bullet", {31'd0, bus.collision_bullet}, 32'd1);
    for (int k = 0; k < 256; k++) cyc(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    fs_pulse();
    check("bul256_mask", {29'd0, bus.bullet_hit_mask}, 32'd1);

    // Enables with display_on low are ignored.
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0);
    fs_pulse();
    check("blank_collision", {31'd0, bus.collision}, 32'd0);
    check("blank_mask", {29'd0, bus.bullet_hit_mask}, 32'd0);
    check("blank_coll_bullet", {31'd0, bus.collision_bullet}, 32'd0);

    // Ship over all three targets counts once per pixel.
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
    fs_pulse();
    check("multi_collision", {31'd0, bus.collision}, THR ? 32'd0 : 32'd1);
    check("multi_mask", {29'd0, bus.bullet_hit_mask}, THR ? 32'd0 : 32'd7);

    // The overlapping frame_start pixel is counted in the new frame.
    cyc(1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
    check("fs_px_prev_frame", {31'd0, bus.collision}, 32'd0);
    ship_px(THR ? 3 : 0); idle(2); fs_pulse();
    check("fs_px_new_frame", {31'd0, bus.collision}, 32'd1);

    // Mid-frame clear, then overlaps in WAIT_FRAME are ignored.
    ship_px(2);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("clear_collision", {31'd0, bus.collision}, 32'd0);
    check("clear_valid", {31'd0, bus.result_valid}, 32'd0);
    ship_px(5);
    fs_pulse();
    check("wait_fs_no_valid", {31'd0, bus.result_valid}, 32'd0);
    idle(3); fs_pulse();
    check("wait_px_ignored", {31'd0, bus.collision}, 32'd0);

    // clear coincident with frame_start after an overlapping frame.
    ship_px(5); fs_pulse();
    check("pre_clear_collision", {31'd0, bus.collision}, 32'd1);
    ship_px(5);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("clr_fs_collision", {31'd0, bus.collision}, 32'd0);
    check("clr_fs_valid", {31'd0, bus.result_valid}, 32'd0);
    ship_px(5); fs_pulse();
    check("after_clr_fs_valid", {31'd0, bus.result_valid}, 32'd0);
    check("after_clr_fs_coll", {31'd0, bus.collision}, 32'd0);
    ship_px(5); fs_pulse();
    check("next_frame_collision", {31'd0, bus.collision}, 32'd1);
    check("next_frame_valid", {31'd0, bus.result_valid}, 32'd1);

    // Asynchronous reset mid-cycle drops outputs without a clock edge.
    ship_px(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_collision", {31'd0, bus.collision}, 32'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
